// File: rtl/vid_pat_pkg.sv
// Shared types and colour tables for the video test-pattern generator.
// Colours are stored as abstract levels and scaled to CW bits at the output.
package vid_pat_pkg;

    typedef enum logic [1:0] {
        BARS    = 2'd0,
        CHECKER = 2'd1,
        BOX     = 2'd2,
        RAMP    = 2'd3
    } pattern_mode_e;

    typedef enum logic [1:0] {
        LV_ZERO,
        LV_FULL,
        LV_HALF,
        LV_QTR
    } level_e;

    typedef struct packed {
        level_e r;
        level_e g;
        level_e b;
    } pix_lv_t;

    localparam pix_lv_t LV_BLACK   = '{LV_ZERO, LV_ZERO, LV_ZERO};
    localparam pix_lv_t LV_WHITE   = '{LV_FULL, LV_FULL, LV_FULL};
    localparam pix_lv_t LV_YELLOW  = '{LV_FULL, LV_FULL, LV_ZERO};
    localparam pix_lv_t LV_CYAN    = '{LV_ZERO, LV_FULL, LV_FULL};
    localparam pix_lv_t LV_GREEN   = '{LV_ZERO, LV_FULL, LV_ZERO};
    localparam pix_lv_t LV_MAGENTA = '{LV_FULL, LV_ZERO, LV_FULL};
    localparam pix_lv_t LV_RED     = '{LV_FULL, LV_ZERO, LV_ZERO};
    localparam pix_lv_t LV_BLUE    = '{LV_ZERO, LV_ZERO, LV_FULL};

    localparam pix_lv_t [7:0] BAR_LV = {
        LV_BLACK, LV_BLUE, LV_RED, LV_MAGENTA,
        LV_GREEN, LV_CYAN, LV_YELLOW, LV_WHITE
    };

    localparam pix_lv_t BOX_IN_LV  = '{LV_FULL, LV_HALF, LV_ZERO};
    localparam pix_lv_t BOX_OUT_LV = '{LV_ZERO, LV_ZERO, LV_QTR};

    // First sx of bar j: smallest x with x*8 >= j*h_res.
    function automatic int bar_thr(input int j, input int h_res);
        return (j * h_res + 7) / 8;
    endfunction

endpackage

// File: rtl/vid_pattern_gen_if.sv
// Pixel bus between the timing generator, the pattern stage and the encoder.
interface vid_pattern_gen_if #(
    parameter int WIDTH = 10,
    parameter int CW    = 4
);
    logic [WIDTH-1:0] sx;
    logic [WIDTH-1:0] sy;
    logic             hsync_in;
    logic             vsync_in;
    logic             de_in;
    logic [CW-1:0]    r;
    logic [CW-1:0]    g;
    logic [CW-1:0]    b;
    logic             hsync_out;
    logic             vsync_out;
    logic             de_out;
    logic             frame_start;

    modport master (
        output sx, sy, hsync_in, vsync_in, de_in,
        input  r, g, b, hsync_out, vsync_out, de_out, frame_start
    );

    modport slave (
        input  sx, sy, hsync_in, vsync_in, de_in,
        output r, g, b, hsync_out, vsync_out, de_out, frame_start
    );
endinterface

// File: rtl/vid_box_mover.sv
// Bouncing-box position, stepped once per frame during vertical blanking.
module vid_box_mover #(
    parameter int WIDTH = 10,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int BOX   = 32,
    parameter int SPEED = 2
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             update,
    output logic [WIDTH-1:0] bx,
    output logic [WIDTH-1:0] by
);
    localparam int W1 = WIDTH + 1;

    logic back_x;
    logic back_y;

    // Returns {new_direction, new_position}; direction 1 = left/up.
    function automatic logic [WIDTH:0] bounce(
        input logic [WIDTH-1:0] p,
        input logic             back,
        input int               res
    );
        logic [W1-1:0] pe;
        pe = {1'b0, p};
        if (!back) begin
            if (pe + W1'(BOX + SPEED) >= W1'(res))
                return {1'b1, WIDTH'(res - BOX)};
            return {1'b0, WIDTH'(pe + W1'(SPEED))};
        end
        if (pe <= W1'(SPEED))
            return {1'b0, {WIDTH{1'b0}}};
        return {1'b1, WIDTH'(pe - W1'(SPEED))};
    endfunction

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            bx     <= '0;
            by     <= '0;
            back_x <= 1'b0;
            back_y <= 1'b0;
        end else if (update) begin
            {back_x, bx} <= bounce(bx, back_x, H_RES);
            {back_y, by} <= bounce(by, back_y, V_RES);
        end
    end
endmodule

// File: rtl/vid_pattern_gen.sv
// Two-stage test-pattern generator: stage 1 decodes, stage 2 colours.
// Mode and box motion only change at frame boundaries to avoid tearing.
module vid_pattern_gen #(
    parameter int WIDTH    = 10,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int CW       = 4,
    parameter int BOX      = 32,
    parameter int SPEED    = 2,
    parameter int CHK_LOG2 = 5
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic [1:0]       mode,
    vid_pattern_gen_if.slave vid
);
    import vid_pat_pkg::*;

    localparam int W1 = WIDTH + 1;

    logic [WIDTH-1:0] box_x;
    logic [WIDTH-1:0] box_y;
    logic             fs_in;
    logic             upd;
    logic             hit;
    pattern_mode_e    mode_q;
    pattern_mode_e    mode_eff;

    logic [WIDTH-1:0] s1_sx;
    logic             s1_sy_bit;
    logic             s1_hs;
    logic             s1_vs;
    logic             s1_de;
    logic             s1_fs;
    logic             s1_hit;
    logic             s1_bars;
    logic             s1_chk;
    logic             s1_box;
    logic             s1_ramp;

    logic [2:0]       bar_k;
    pix_lv_t          lv;

    assign fs_in    = (vid.sx == '0) && (vid.sy == '0);
    assign upd      = (vid.sx == '0) && (vid.sy == WIDTH'(V_RES));
    assign mode_eff = fs_in ? pattern_mode_e'(mode) : mode_q;

    assign hit = ({1'b0, vid.sx} >= {1'b0, box_x})
              && ({1'b0, vid.sx} <  {1'b0, box_x} + W1'(BOX))
              && ({1'b0, vid.sy} >= {1'b0, box_y})
              && ({1'b0, vid.sy} <  {1'b0, box_y} + W1'(BOX));

    vid_box_mover #(
        .WIDTH (WIDTH),
        .H_RES (H_RES),
        .V_RES (V_RES),
        .BOX   (BOX),
        .SPEED (SPEED)
    ) u_box (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .update    (upd),
        .bx        (box_x),
        .by        (box_y)
    );

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            mode_q    <= vid_pat_pkg::BARS;
            s1_sx     <= '0;
            s1_sy_bit <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_de     <= 1'b0;
            s1_fs     <= 1'b0;
            s1_hit    <= 1'b0;
            s1_bars   <= 1'b0;
            s1_chk    <= 1'b0;
            s1_box    <= 1'b0;
            s1_ramp   <= 1'b0;
        end else begin
            if (fs_in)
                mode_q <= mode_eff;
            s1_sx     <= vid.sx;
            s1_sy_bit <= vid.sy[CHK_LOG2];
            s1_hs     <= vid.hsync_in;
            s1_vs     <= vid.vsync_in;
            s1_de     <= vid.de_in;
            s1_fs     <= fs_in;
            s1_hit    <= hit;
            s1_bars   <= mode_eff == vid_pat_pkg::BARS;
            s1_chk    <= mode_eff == vid_pat_pkg::CHECKER;
            s1_box    <= mode_eff == vid_pat_pkg::BOX;
            s1_ramp   <= mode_eff == vid_pat_pkg::RAMP;
        end
    end

    // Bar index by comparator chain, avoiding a divider.
    always_comb begin
        bar_k = '0;
        for (int j = 1; j < 8; j++)
            if ({1'b0, s1_sx} >= W1'(bar_thr(j, H_RES)))
                bar_k = bar_k + 3'd1;
    end

    always_comb begin
        lv = LV_BLACK;
        unique case (1'b1)
            s1_bars: lv = BAR_LV[bar_k];
            s1_chk:  lv = (s1_sx[CHK_LOG2] ^ s1_sy_bit) ? LV_BLACK : LV_WHITE;
            s1_box:  lv = s1_hit ? BOX_IN_LV : BOX_OUT_LV;
            default: lv = LV_BLACK;
        endcase
    end

    function automatic logic [CW-1:0] lv2c(input level_e l);
        unique case (l)
            LV_FULL: return '1;
            LV_HALF: return CW'(1) << (CW - 1);
            LV_QTR:  return CW'(1) << (CW - 2);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            vid.r           <= '0;
            vid.g           <= '0;
            vid.b           <= '0;
            vid.hsync_out   <= 1'b0;
            vid.vsync_out   <= 1'b0;
            vid.de_out      <= 1'b0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.hsync_out   <= s1_hs;
            vid.vsync_out   <= s1_vs;
            vid.de_out      <= s1_de;
            vid.frame_start <= s1_fs;
            if (!s1_de) begin
                vid.r <= '0;
                vid.g <= '0;
                vid.b <= '0;
            end else if (s1_ramp) begin
                vid.r <= s1_sx[CW+CHK_LOG2-1:CHK_LOG2];
                vid.g <= s1_sx[CW+CHK_LOG2-1:CHK_LOG2];
                vid.b <= s1_sx[CW+CHK_LOG2-1:CHK_LOG2];
            end else begin
                vid.r <= lv2c(lv.r);
                vid.g <= lv2c(lv.g);
                vid.b <= lv2c(lv.b);
            end
        end
    end
endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen: reset, bars, sync delay, mode latch,
// box bounce and mid-frame reset, with hand-computed expectations.
module tb_vid_pattern_gen;
    logic       clk_pix = 1'b0;
    logic       rst_pix_n;
    logic [1:0] mode;
    int         errors = 0;
    int         checks = 0;

    vid_pattern_gen_if #(.WIDTH(10), .CW(4)) vid ();

    vid_pattern_gen #(
        .WIDTH(10), .H_RES(640), .V_RES(480), .CW(4),
        .BOX(32), .SPEED(2), .CHK_LOG2(5)
    ) dut (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .mode      (mode),
        .vid       (vid)
    );

    always #5 clk_pix = ~clk_pix;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input int x, input int y,
                          input logic h, input logic v, input logic d);
        @(negedge clk_pix);
        vid.sx       = x[9:0];
        vid.sy       = y[9:0];
        vid.hsync_in = h;
        vid.vsync_in = v;
        vid.de_in    = d;
    endtask

    // Drive one pixel, then idle blanking; returns when its result is visible.
    task automatic pix(input int x, input int y, input logic d);
        set_in(x, y, 1'b0, 1'b0, d);
        set_in(700, 10, 1'b0, 1'b0, 1'b0);
        @(negedge clk_pix);
    endtask

    task automatic test_reset();
        rst_pix_n = 1'b0;
        vid.sx = '0; vid.sy = '0;
        vid.hsync_in = 1'b1; vid.vsync_in = 1'b1; vid.de_in = 1'b1;
        repeat (4) @(negedge clk_pix);
        checks++;
        if ({vid.r, vid.g, vid.b, vid.hsync_out, vid.vsync_out,
             vid.de_out, vid.frame_start} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h%h%h %b%b%b%b required all 0",
                     vid.r, vid.g, vid.b, vid.hsync_out, vid.vsync_out,
                     vid.de_out, vid.frame_start);
        end
        rst_pix_n = 1'b1;
        vid.hsync_in = 1'b0; vid.vsync_in = 1'b0;
        @(negedge clk_pix);
        checks++;
        if (vid.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_early: frame_start=%b required 0", vid.frame_start);
        end
        vid.sx = 10'd700; vid.sy = 10'd10; vid.de_in = 1'b0;
        @(negedge clk_pix);
        checks++;
        if (vid.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL fs_pulse: frame_start=%b required 1", vid.frame_start);
        end
        checks++;
        if ({vid.r, vid.g, vid.b} !== 12'hFFF) begin
            errors++;
            $display("FAIL fs_pixel: rgb=%h%h%h required fff", vid.r, vid.g, vid.b);
        end
        @(negedge clk_pix);
        checks++;
        if (vid.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_width: frame_start=%b required 0", vid.frame_start);
        end
    endtask

    task automatic test_bars();
        int          xs[11] = '{0, 79, 80, 160, 240, 320, 400, 480, 560, 639, 700};
        logic        ds[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [11:0] ex[11] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000, 12'h000,
                                12'h000};
        for (int i = 0; i < 11; i++) begin
            pix(xs[i], 5, ds[i]);
            checks++;
            if ({vid.r, vid.g, vid.b} !== ex[i]) begin
                errors++;
                $display("FAIL bars sx=%0d: rgb=%h%h%h required %h",
                         xs[i], vid.r, vid.g, vid.b, ex[i]);
            end
        end
    endtask

    task automatic test_sync();
        logic hh[200], vv[200], dd[200];
        int   hs_bad = 0, vs_bad = 0, de_bad = 0;
        int   hs_w = 0, vs_w = 0, de_w = 0;
        for (int i = 0; i < 202; i++) begin
            @(negedge clk_pix);
            if (i >= 2) begin
                if (vid.hsync_out !== hh[i-2]) hs_bad++;
                if (vid.vsync_out !== vv[i-2]) vs_bad++;
                if (vid.de_out    !== dd[i-2]) de_bad++;
                if (vid.hsync_out === 1'b1) hs_w++;
                if (vid.vsync_out === 1'b1) vs_w++;
                if (vid.de_out    === 1'b1) de_w++;
            end
            if (i < 200) begin
                hh[i] = (600 + i >= 656) && (600 + i < 752);
                vv[i] = (i >= 20) && (i < 50);
                dd[i] = (600 + i < 640);
                vid.sx = 10'(600 + i); vid.sy = 10'd490;
                vid.hsync_in = hh[i]; vid.vsync_in = vv[i]; vid.de_in = dd[i];
            end else begin
                vid.sx = 10'd700; vid.sy = 10'd10;
                vid.hsync_in = 1'b0; vid.vsync_in = 1'b0; vid.de_in = 1'b0;
            end
        end
        checks++;
        if (hs_bad !== 0) begin
            errors++; $display("FAIL hsync_align: %0d bad cycles required 0", hs_bad);
        end
        checks++;
        if (vs_bad !== 0) begin
            errors++; $display("FAIL vsync_align: %0d bad cycles required 0", vs_bad);
        end
        checks++;
        if (de_bad !== 0) begin
            errors++; $display("FAIL de_align: %0d bad cycles required 0", de_bad);
        end
        checks++;
        if (hs_w !== 96) begin
            errors++; $display("FAIL hsync_width: %0d required 96", hs_w);
        end
        checks++;
        if (vs_w !== 30) begin
            errors++; $display("FAIL vsync_width: %0d required 30", vs_w);
        end
        checks++;
        if (de_w !== 40) begin
            errors++; $display("FAIL de_width: %0d required 40", de_w);
        end
    endtask

    task automatic test_mode_switch();
        int          mx[10] = '{100, 32, 0, 32, 32, 64, 0, 64, 511, 512};
        int          my[10] = '{200, 0, 0, 0, 32, 0, 0, 5, 5, 5};
        logic [1:0]  mm[10] = '{1, 1, 1, 1, 1, 3, 3, 3, 3, 3};
        logic [11:0] ex[10] = '{12'hFF0, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF,
                                12'hFFF, 12'h000, 12'h222, 12'hFFF, 12'h000};
        for (int i = 0; i < 10; i++) begin
            mode = mm[i];
            pix(mx[i], my[i], 1'b1);
            checks++;
            if ({vid.r, vid.g, vid.b} !== ex[i]) begin
                errors++;
                $display("FAIL mode_switch[%0d] (%0d,%0d): rgb=%h%h%h required %h",
                         i, mx[i], my[i], vid.r, vid.g, vid.b, ex[i]);
            end
        end
    endtask

    task automatic test_box_bounce();
        int          bxs[7] = '{0, 608, 607, 639, 608, 639, 700};
        int          bys[7] = '{0, 288, 288, 319, 320, 287, 300};
        logic        bds[7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [11:0] ex[7]  = '{12'h004, 12'hF80, 12'h004, 12'hF80,
                                12'h004, 12'h004, 12'h000};
        repeat (303) begin
            set_in(0, 480, 1'b0, 1'b0, 1'b0);
            set_in(700, 10, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk_pix);
        checks++;
        if (dut.box_x !== 10'd606 || dut.box_y !== 10'd290) begin
            errors++;
            $display("FAIL box_preload: (%0d,%0d) required (606,290)",
                     dut.box_x, dut.box_y);
        end
        set_in(0, 480, 1'b0, 1'b0, 1'b0);
        set_in(700, 10, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut.box_x !== 10'd608 || dut.box_y !== 10'd288) begin
            errors++;
            $display("FAIL box_bounce: (%0d,%0d) required (608,288)",
                     dut.box_x, dut.box_y);
        end
        mode = 2'd2;
        for (int i = 0; i < 7; i++) begin
            pix(bxs[i], bys[i], bds[i]);
            checks++;
            if ({vid.r, vid.g, vid.b} !== ex[i]) begin
                errors++;
                $display("FAIL box_pixel (%0d,%0d): rgb=%h%h%h required %h",
                         bxs[i], bys[i], vid.r, vid.g, vid.b, ex[i]);
            end
        end
        set_in(0, 480, 1'b0, 1'b0, 1'b0);
        set_in(700, 10, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut.box_x !== 10'd606 || dut.box_y !== 10'd286) begin
            errors++;
            $display("FAIL box_return: (%0d,%0d) required (606,286)",
                     dut.box_x, dut.box_y);
        end
    endtask

    task automatic test_reset_mid();
        int          rx[4] = '{300, 0, 31, 32};
        int          ry[4] = '{100, 0, 31, 0};
        logic [11:0] ex[4] = '{12'h0F0, 12'hF80, 12'hF80, 12'h004};
        mode = 2'd2;
        set_in(300, 100, 1'b1, 1'b1, 1'b1);
        @(negedge clk_pix);
        rst_pix_n = 1'b0;
        vid.sx = 10'd700; vid.sy = 10'd10;
        vid.hsync_in = 1'b0; vid.vsync_in = 1'b0; vid.de_in = 1'b0;
        @(negedge clk_pix);
        checks++;
        if ({vid.r, vid.g, vid.b, vid.hsync_out, vid.vsync_out,
             vid.de_out, vid.frame_start} !== 16'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h%h%h %b%b%b%b required all 0",
                     vid.r, vid.g, vid.b, vid.hsync_out, vid.vsync_out,
                     vid.de_out, vid.frame_start);
        end
        checks++;
        if (dut.box_x !== 10'd0 || dut.box_y !== 10'd0) begin
            errors++;
            $display("FAIL midreset_box: (%0d,%0d) required (0,0)",
                     dut.box_x, dut.box_y);
        end
        rst_pix_n = 1'b1;
        repeat (2) @(negedge clk_pix);
        checks++;
        if ({vid.r, vid.g, vid.b, vid.hsync_out, vid.vsync_out,
             vid.de_out, vid.frame_start} !== 16'h0) begin
            errors++;
            $display("FAIL midreset_stale: got %h%h%h %b%b%b%b required all 0",
                     vid.r, vid.g, vid.b, vid.hsync_out, vid.vsync_out,
                     vid.de_out, vid.frame_start);
        end
        for (int i = 0; i < 4; i++) begin
            pix(rx[i], ry[i], 1'b1);
            checks++;
            if ({vid.r, vid.g, vid.b} !== ex[i]) begin
                errors++;
                $display("FAIL midreset_pixel (%0d,%0d): rgb=%h%h%h required %h",
                         rx[i], ry[i], vid.r, vid.g, vid.b, ex[i]);
            end
        end
    endtask

    initial begin
        rst_pix_n = 1'b0;
        mode = 2'd0;
        vid.sx = 10'd700; vid.sy = 10'd10;
        vid.hsync_in = 1'b0; vid.vsync_in = 1'b0; vid.de_in = 1'b0;
        test_reset();
        test_bars();
        test_sync();
        test_mode_switch();
        test_box_bounce();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
